imm_gen_pipe: RTL
=================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, output immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter IMM_SRC_WIDTH, default 3, immediate-format selector width.
REQ-003 SHALL have parameter TAG_WIDTH, default 5, sideband tag width carried with each entry.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, illegal-format counter width.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port Instr, input, 32, instruction word.
REQ-008 SHALL have port ImmSrc, input, IMM_SRC_WIDTH, immediate format select.
REQ-009 SHALL have port TagIn, input, TAG_WIDTH, sideband tag travelling with Instr.
REQ-010 SHALL have port InValid, input, 1, request valid.
REQ-011 SHALL have port InReady, output, 1, block can accept.
REQ-012 SHALL have port Flush, input, 1, synchronous discard of all buffered entries.
REQ-013 SHALL have port ImmOp, output, DATA_WIDTH, extended immediate.
REQ-014 SHALL have port TagOut, output, TAG_WIDTH, tag of the head entry.
REQ-015 SHALL have port OutValid, output, 1, head entry valid.
REQ-016 SHALL have port OutReady, input, 1, consumer accepts.
REQ-017 SHALL have port IllegalCnt, output, CNT_WIDTH, saturating count of accepted illegal formats.

Function
REQ-018 Input transfer SHALL occur when InValid and InReady are both 1; output transfer SHALL occur when OutValid and OutReady are both 1.
REQ-019 Immediate decode per ImmSrc, all sign extensions from Instr[31] to DATA_WIDTH: 000 I {Instr[31:20]}; 001 S {Instr[31:25],Instr[11:7]}; 010 B {Instr[31],Instr[7],Instr[30:25],Instr[11:8],0}; 011 U {Instr[31:12],12'b0} sign-extended; 100 J {Instr[31],Instr[19:12],Instr[20],Instr[30:21],0}.
REQ-020 ImmSrc 101 (CSR zimm) SHALL zero-extend Instr[19:15]; ImmSrc 110 (shamt) SHALL zero-extend Instr[24:20] when DATA_WIDTH=32, Instr[25:20] when DATA_WIDTH=64.
REQ-021 ImmSrc 111 SHALL be illegal: stored ImmOp = 0; IllegalCnt increments by 1 on that input transfer, saturating at all-ones.
REQ-022 Decode SHALL occur before storage; the buffer SHALL hold ImmOp and TagOut only, 2 entries, FIFO order.
REQ-023 Latency: an entry transferred in cycle N into an empty buffer SHALL appear on OutValid/ImmOp/TagOut in cycle N+1.
REQ-024 InReady SHALL be 1 when fewer than 2 entries are held and Flush is 0, registered-only (no combinational path from OutReady or InValid).
REQ-025 Simultaneous input and output transfer with 1 entry held SHALL keep occupancy 1 and present the new entry next cycle.
REQ-026 With 2 entries held, InReady SHALL be 0; an output transfer in that cycle SHALL make InReady 1 in the next cycle.
REQ-027 OutValid, ImmOp and TagOut SHALL be stable while OutValid=1 and OutReady=0.
REQ-028 Flush=1 SHALL empty the buffer at the next edge, drop any same-cycle input (InReady 0), and leave IllegalCnt unchanged; an output transfer in the Flush cycle still completes.
REQ-029 When OutValid=0, ImmOp and TagOut SHALL be 0.

Reset
REQ-030 rst_n low SHALL immediately force: buffer empty, OutValid 0, ImmOp 0, TagOut 0, IllegalCnt 0, InReady 0.
REQ-031 InReady SHALL rise on the first rising clk edge after rst_n deasserts; reset mid-transfer SHALL discard all entries without producing output.

Verification
REQ-032 DATA_WIDTH=32, Instr=0xFFF00093, ImmSrc=000, TagIn=3, OutReady=1 -> next cycle OutValid=1, ImmOp=0xFFFFFFFF, TagOut=3.
REQ-033 Instr=0xFE000EE3, ImmSrc=010 -> ImmOp=0xFFFFFFFC; Instr=0x0000006F with bit20=1 (0x0010006F), ImmSrc=100 -> ImmOp=0x00000800.
REQ-034 DATA_WIDTH=64, Instr=0x80000037, ImmSrc=011 -> ImmOp=0xFFFFFFFF80000000; Instr=0x03F01013, ImmSrc=110 -> ImmOp=0x3F.
REQ-035 OutReady=0, push tags 1,2,3 back-to-back -> InReady 0 after 2 accepts, tag 3 held; OutReady=1 -> TagOut 1,2,3 in order, no loss or duplication.
REQ-036 300 transfers with ImmSrc=111 -> each ImmOp=0, IllegalCnt reaches 255 and holds; Flush with 2 entries held -> OutValid 0 next cycle; rst_n low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Decodes the immediate field of a RISC-V instruction word and buffers the
//   extended result, together with a sideband tag, in a 2-entry FIFO with a
//   valid/ready handshake on both sides.
//
// Parameters
//   DATA_WIDTH    : extended immediate width (32 or 64)
//   IMM_SRC_WIDTH : immediate-format selector width
//   TAG_WIDTH     : sideband tag width
//   CNT_WIDTH     : illegal-format counter width
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   Instr      in   instruction word
//   ImmSrc     in   immediate format select
//   TagIn      in   tag travelling with Instr
//   InValid    in   request valid
//   InReady    out  block can accept (registered, gated only by Flush)
//   Flush      in   synchronous discard of all buffered entries
//   ImmOp      out  extended immediate of the head entry (0 when empty)
//   TagOut     out  tag of the head entry (0 when empty)
//   OutValid   out  head entry valid
//   OutReady   in   consumer accepts
//   IllegalCnt out  saturating count of accepted illegal formats
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int DATA_WIDTH    = 32,
  parameter int IMM_SRC_WIDTH = 3,
  parameter int TAG_WIDTH     = 5,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              Instr,
  input  logic [IMM_SRC_WIDTH-1:0] ImmSrc,
  input  logic [TAG_WIDTH-1:0]     TagIn,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic                     Flush,
  output logic [DATA_WIDTH-1:0]    ImmOp,
  output logic [TAG_WIDTH-1:0]     TagOut,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [CNT_WIDTH-1:0]     IllegalCnt
);

  // Buffer occupancy
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } occ_t;

  occ_t                  r_state;
  logic                  r_in_ready;
  logic [DATA_WIDTH-1:0] r_imm0;
  logic [DATA_WIDTH-1:0] r_imm1;
  logic [TAG_WIDTH-1:0]  r_tag0;
  logic [TAG_WIDTH-1:0]  r_tag1;
  logic [CNT_WIDTH-1:0]  r_illegal_cnt;

  logic [DATA_WIDTH-1:0] w_imm;
  logic                  w_illegal;
  logic                  w_shamt_hi;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_unused_opcode;

  // The opcode field carries no immediate bits
  assign w_unused_opcode = ^Instr[6:0];

  // Shift amounts are 6 bits wide only on a 64-bit datapath
  assign w_shamt_hi = (DATA_WIDTH == 64) ? Instr[25] : 1'b0;

  // ---------------------------------------------------------------------------
  // Immediate decode (before storage). Replication counts are chosen so that
  // every one is at least 1 for both legal DATA_WIDTH values; U-type uses
  // Instr[31] as its own sign bit plus the replicated extension.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_imm     = '0;
    w_illegal = 1'b0;
    case (ImmSrc)
      IMM_SRC_WIDTH'(0): // I
        w_imm = {{(DATA_WIDTH-12){Instr[31]}}, Instr[31:20]};
      IMM_SRC_WIDTH'(1): // S
        w_imm = {{(DATA_WIDTH-12){Instr[31]}}, Instr[31:25], Instr[11:7]};
      IMM_SRC_WIDTH'(2): // B
        w_imm = {{(DATA_WIDTH-12){Instr[31]}}, Instr[7], Instr[30:25],
                 Instr[11:8], 1'b0};
      IMM_SRC_WIDTH'(3): // U
        w_imm = {{(DATA_WIDTH-31){Instr[31]}}, Instr[30:12], 12'b0};
      IMM_SRC_WIDTH'(4): // J
        w_imm = {{(DATA_WIDTH-20){Instr[31]}}, Instr[19:12], Instr[20],
                 Instr[30:21], 1'b0};
      IMM_SRC_WIDTH'(5): // CSR zimm
        w_imm = {{(DATA_WIDTH-5){1'b0}}, Instr[19:15]};
      IMM_SRC_WIDTH'(6): // shamt
        w_imm = {{(DATA_WIDTH-6){1'b0}}, w_shamt_hi, Instr[24:20]};
      default: begin
        w_imm     = '0;
        w_illegal = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake. InReady is a register gated only by Flush, so there is no
  // combinational path from OutReady or InValid.
  // ---------------------------------------------------------------------------
  assign InReady  = r_in_ready & ~Flush;
  assign OutValid = (r_state != S_EMPTY);
  assign w_push   = InValid & InReady;
  assign w_pop    = OutValid & OutReady;

  // Slot 0 is always the head; it is cleared whenever it becomes empty so the
  // outputs read 0 without extra gating.
  assign ImmOp      = r_imm0;
  assign TagOut     = r_tag0;
  assign IllegalCnt = r_illegal_cnt;

  // ---------------------------------------------------------------------------
  // Two-entry buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
      r_imm0     <= '0;
      r_imm1     <= '0;
      r_tag0     <= '0;
      r_tag1     <= '0;
    end else begin
      // Ready next cycle unless the buffer ends up full
      r_in_ready <= 1'b1;
      if (Flush) begin
        r_state <= S_EMPTY;
        r_imm0  <= '0;
        r_imm1  <= '0;
        r_tag0  <= '0;
        r_tag1  <= '0;
      end else begin
        case (r_state)
          S_EMPTY: begin
            if (w_push) begin
              r_imm0  <= w_imm;
              r_tag0  <= TagIn;
              r_state <= S_ONE;
            end
          end
          S_ONE: begin
            if (w_push && w_pop) begin
              r_imm0 <= w_imm;
              r_tag0 <= TagIn;
            end else if (w_push) begin
              r_imm1     <= w_imm;
              r_tag1     <= TagIn;
              r_state    <= S_FULL;
              r_in_ready <= 1'b0;
            end else if (w_pop) begin
              r_imm0  <= '0;
              r_tag0  <= '0;
              r_state <= S_EMPTY;
            end
          end
          S_FULL: begin
            // No push possible while full
            if (w_pop) begin
              r_imm0  <= r_imm1;
              r_tag0  <= r_tag1;
              r_imm1  <= '0;
              r_tag1  <= '0;
              r_state <= S_ONE;
            end else begin
              r_in_ready <= 1'b0;
            end
          end
          default: begin
            r_state <= S_EMPTY;
            r_imm0  <= '0;
            r_imm1  <= '0;
            r_tag0  <= '0;
            r_tag1  <= '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating illegal-format counter (push is already blocked during Flush)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_cnt <= '0;
    end else if (w_push && w_illegal && (r_illegal_cnt != '1)) begin
      r_illegal_cnt <= r_illegal_cnt + 1'b1;
    end
  end

endmodule
